// File: rtl/dds_sweep_pkg.sv
// Shared types, register map and reset defaults for the DDS frequency-sweep scheduler.
package dds_sweep_pkg;

  localparam int unsigned DDS_FCW_W  = 24;
  localparam int unsigned DDS_CNT_W  = 16;
  localparam int unsigned DDS_SETTLE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CAPREQ = 3'd2,
    ST_DWELL  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] ADDR_BASE0 = 3'd0;
  localparam logic [2:0] ADDR_BASE1 = 3'd1;
  localparam logic [2:0] ADDR_BASE2 = 3'd2;
  localparam logic [2:0] ADDR_STEP0 = 3'd3;
  localparam logic [2:0] ADDR_STEP1 = 3'd4;
  localparam logic [2:0] ADDR_STEP2 = 3'd5;
  localparam logic [2:0] ADDR_NSTEP = 3'd6;
  localparam logic [2:0] ADDR_DWELL = 3'd7;

  localparam int unsigned RST_BASE  = 0;
  localparam int unsigned RST_STEP  = 0;
  localparam int unsigned RST_NSTEP = 1;
  localparam int unsigned RST_DWELL = 1;

endpackage

// File: rtl/dds_fcw_stepper.sv
// One DDS channel: BASE/STEP config registers and the FCW accumulator they drive.
module dds_fcw_stepper
  import dds_sweep_pkg::*;
#(
  parameter int unsigned W = DDS_FCW_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         base_we,
  input  logic         step_we,
  input  logic [W-1:0] wdata,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] fcw
);

  logic [W-1:0] base_q;
  logic [W-1:0] step_q;
  logic [W-1:0] step_run;

  // STEP is snapshotted at load so a write in the start cycle only affects the next sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= W'(RST_BASE);
      step_q   <= W'(RST_STEP);
      step_run <= W'(RST_STEP);
      fcw      <= '0;
    end else begin
      if (base_we) base_q <= wdata;
      if (step_we) step_q <= wdata;
      if (load) begin
        fcw      <= base_q;
        step_run <= step_q;
      end else if (adv) begin
        fcw <= fcw + step_run;
      end
    end
  end

endmodule

// File: rtl/dds_sweep_sched.sv
// Sweep scheduler: loads/steps three DDS FCWs, waits out pipeline latency,
// then requests an FFT capture per step over a valid/ready handshake.
module dds_sweep_sched
  import dds_sweep_pkg::*;
#(
  parameter int unsigned FCW_W  = DDS_FCW_W,
  parameter int unsigned CNT_W  = DDS_CNT_W,
  parameter int unsigned SETTLE = DDS_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [FCW_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             abort,
  input  logic             cap_ready,
  output logic [FCW_W-1:0] fcw0,
  output logic [FCW_W-1:0] fcw1,
  output logic [FCW_W-1:0] fcw2,
  output logic             fcw_upd,
  output logic             cap_valid,
  output logic [CNT_W-1:0] cap_idx,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nstep_cfg;
  logic [CNT_W-1:0] dwell_cfg;
  logic [CNT_W-1:0] nstep_run;
  logic [CNT_W-1:0] dwell_run;

  logic             cfg_ok_c;
  logic [2:0]       base_we_c;
  logic [2:0]       step_we_c;
  logic [CNT_W-1:0] nstep_eff_c;
  logic [CNT_W-1:0] dwell_eff_c;
  logic [CNT_W:0]   idx_inc_c;
  logic             more_c;
  logic             load_c;
  logic             dwell_last_c;
  logic             adv_c;

  assign cfg_ok_c     = cfg_we && !busy;
  assign nstep_eff_c  = (nstep_cfg == '0) ? CNT_W'(1) : nstep_cfg;
  assign dwell_eff_c  = (dwell_cfg == '0) ? CNT_W'(1) : dwell_cfg;
  assign idx_inc_c    = {1'b0, cap_idx} + {{CNT_W{1'b0}}, 1'b1};
  assign more_c       = idx_inc_c < {1'b0, nstep_run};
  assign load_c       = (state == ST_IDLE) && start && !abort;
  assign dwell_last_c = (state == ST_DWELL) && !abort && (cnt == dwell_run - CNT_W'(1));
  assign adv_c        = dwell_last_c && more_c;

  // Decode per-channel BASE/STEP write enables.
  always_comb begin
    base_we_c = '0;
    step_we_c = '0;
    if (cfg_ok_c) begin
      case (cfg_addr)
        ADDR_BASE0: base_we_c[0] = 1'b1;
        ADDR_BASE1: base_we_c[1] = 1'b1;
        ADDR_BASE2: base_we_c[2] = 1'b1;
        ADDR_STEP0: step_we_c[0] = 1'b1;
        ADDR_STEP1: step_we_c[1] = 1'b1;
        ADDR_STEP2: step_we_c[2] = 1'b1;
        default: ;
      endcase
    end
  end

  dds_fcw_stepper #(.W(FCW_W)) u_ch0 (
    .clk(clk), .rst(rst), .base_we(base_we_c[0]), .step_we(step_we_c[0]),
    .wdata(cfg_wdata), .load(load_c), .adv(adv_c), .fcw(fcw0)
  );

  dds_fcw_stepper #(.W(FCW_W)) u_ch1 (
    .clk(clk), .rst(rst), .base_we(base_we_c[1]), .step_we(step_we_c[1]),
    .wdata(cfg_wdata), .load(load_c), .adv(adv_c), .fcw(fcw1)
  );

  dds_fcw_stepper #(.W(FCW_W)) u_ch2 (
    .clk(clk), .rst(rst), .base_we(base_we_c[2]), .step_we(step_we_c[2]),
    .wdata(cfg_wdata), .load(load_c), .adv(adv_c), .fcw(fcw2)
  );

  // Sweep FSM with counters, handshake and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      nstep_cfg <= CNT_W'(RST_NSTEP);
      dwell_cfg <= CNT_W'(RST_DWELL);
      nstep_run <= CNT_W'(RST_NSTEP);
      dwell_run <= CNT_W'(RST_DWELL);
      fcw_upd   <= 1'b0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      fcw_upd <= 1'b0;
      done    <= 1'b0;

      if (cfg_ok_c && (cfg_addr == ADDR_NSTEP)) nstep_cfg <= cfg_wdata[CNT_W-1:0];
      if (cfg_ok_c && (cfg_addr == ADDR_DWELL)) dwell_cfg <= cfg_wdata[CNT_W-1:0];

      if (abort && busy) begin
        // Abort beats any coincident handshake; FCWs simply hold.
        state     <= ST_IDLE;
        busy      <= 1'b0;
        cap_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (load_c) begin
              state     <= ST_SETTLE;
              busy      <= 1'b1;
              fcw_upd   <= 1'b1;
              cap_idx   <= '0;
              cnt       <= '0;
              nstep_run <= nstep_eff_c;
              dwell_run <= dwell_eff_c;
            end
          end
          ST_SETTLE: begin
            if (cnt == CNT_W'(SETTLE - 1)) begin
              state     <= ST_CAPREQ;
              cap_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_CAPREQ: begin
            if (cap_ready) begin
              state     <= ST_DWELL;
              cap_valid <= 1'b0;
              cnt       <= '0;
            end
          end
          ST_DWELL: begin
            if (dwell_last_c) begin
              cnt <= '0;
              if (more_c) begin
                state   <= ST_SETTLE;
                fcw_upd <= 1'b1;
                cap_idx <= idx_inc_c[CNT_W-1:0];
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_sched.sv
// Directed, cycle-exact bench for dds_sweep_sched with hand-computed expectations.
module tb_dds_sweep_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [23:0] cfg_wdata;
  logic        start;
  logic        abort;
  logic        cap_ready;
  logic [23:0] fcw0;
  logic [23:0] fcw1;
  logic [23:0] fcw2;
  logic        fcw_upd;
  logic        cap_valid;
  logic [15:0] cap_idx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  dds_sweep_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .abort(abort), .cap_ready(cap_ready),
    .fcw0(fcw0), .fcw1(fcw1), .fcw2(fcw2), .fcw_upd(fcw_upd), .cap_valid(cap_valid),
    .cap_idx(cap_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({fcw0, fcw1, fcw2, fcw_upd, cap_valid, cap_idx, busy, done} !== '0) begin
      errors++; $display("FAIL reset_outputs got fcw0=%0d fcw1=%0d fcw2=%0d upd=%b cv=%b idx=%0d busy=%b done=%b want all 0",
                         fcw0, fcw1, fcw2, fcw_upd, cap_valid, cap_idx, busy, done);
    end
  endtask

  task automatic test_defaults();
    int d0;
    d0 = done_cnt;
    cap_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({fcw_upd, busy} !== 2'b11 || {fcw0, fcw1, fcw2} !== 72'd0 || cap_idx !== 16'd0) begin
      errors++; $display("FAIL def_load got upd=%b busy=%b fcw0=%0d idx=%0d want upd=1 busy=1 fcw=0 idx=0", fcw_upd, busy, fcw0, cap_idx);
    end
    tick();
    checks++;
    if (fcw_upd !== 1'b0) begin errors++; $display("FAIL def_upd_pulse got %b want 0", fcw_upd); end
    repeat (6) tick();
    checks++;
    if (cap_valid !== 1'b0) begin errors++; $display("FAIL def_cv_early got %b want 0 at t+8", cap_valid); end
    tick();
    checks++;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL def_cv_rise got %b want 1 at t+9", cap_valid); end
    tick();
    checks++;
    if ({cap_valid, done, busy} !== 3'b001) begin
      errors++; $display("FAIL def_dwell got cv=%b done=%b busy=%b want 0 0 1", cap_valid, done, busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL def_done got done=%b busy=%b want 1 0", done, busy); end
    tick();
    checks++;
    if ({done, busy} !== 2'b00 || done_cnt !== d0 + 1) begin
      errors++; $display("FAIL def_after got done=%b busy=%b pulses=%0d want 0 0 %0d", done, busy, done_cnt - d0, 1);
    end
  endtask

  task automatic test_multi_step();
    int d0;
    logic [23:0] e0, e1, e2;
    cfg_write(3'd0, 24'd100); cfg_write(3'd1, 24'd200); cfg_write(3'd2, 24'd300);
    cfg_write(3'd3, 24'd10);  cfg_write(3'd4, 24'd20);  cfg_write(3'd5, 24'd30);
    cfg_write(3'd6, 24'd3);   cfg_write(3'd7, 24'd4);
    cap_ready = 1'b1;
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e0 = 24'(100 + 10 * k); e1 = 24'(200 + 20 * k); e2 = 24'(300 + 30 * k);
      checks++;
      if (fcw_upd !== 1'b1 || fcw0 !== e0 || fcw1 !== e1 || fcw2 !== e2) begin
        errors++; $display("FAIL ms_upd%0d got upd=%b fcw=%0d/%0d/%0d want 1 %0d/%0d/%0d", k, fcw_upd, fcw0, fcw1, fcw2, e0, e1, e2);
      end
      for (int i = 0; i < 8; i++) begin
        start = (k == 1 && i == 2);
        tick();
      end
      start = 1'b0;
      checks++;
      if (cap_valid !== 1'b1 || cap_idx !== 16'(k)) begin
        errors++; $display("FAIL ms_cap%0d got cv=%b idx=%0d want 1 %0d", k, cap_valid, cap_idx, k);
      end
      repeat (4) tick();
      checks++;
      if ({cap_valid, busy, fcw_upd} !== 3'b010) begin
        errors++; $display("FAIL ms_dwell%0d got cv=%b busy=%b upd=%b want 0 1 0", k, cap_valid, busy, fcw_upd);
      end
      tick();
    end
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL ms_done got done=%b busy=%b want 1 0", done, busy); end
    tick();
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ms_done_count got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    cap_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    tick();
    cap_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if (fcw_upd !== 1'b1 || fcw0 !== 24'd110) begin
      errors++; $display("FAIL bp_upd1 got upd=%b fcw0=%0d want 1 110", fcw_upd, fcw0);
    end
    repeat (8) tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) cap_ready = 1'b1;
      checks++;
      if (cap_valid !== 1'b1 || cap_idx !== 16'd1) begin
        errors++; $display("FAIL bp_hold%0d got cv=%b idx=%0d want 1 1", i, cap_valid, cap_idx);
      end
      tick();
    end
    checks++;
    if (cap_valid !== 1'b0) begin errors++; $display("FAIL bp_release got cv=%b want 0", cap_valid); end
    repeat (4) tick();
    checks++;
    if (fcw_upd !== 1'b1 || fcw0 !== 24'd120 || fcw2 !== 24'd360 || cap_idx !== 16'd2) begin
      errors++; $display("FAIL bp_upd2 got upd=%b fcw0=%0d fcw2=%0d idx=%0d want 1 120 360 2", fcw_upd, fcw0, fcw2, cap_idx);
    end
    repeat (8) tick();
    checks++;
    if (cap_valid !== 1'b1 || cap_idx !== 16'd2) begin
      errors++; $display("FAIL bp_cap2 got cv=%b idx=%0d want 1 2", cap_valid, cap_idx);
    end
    repeat (5) tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_wrap();
    cfg_write(3'd0, 24'd16777211); cfg_write(3'd3, 24'd10);
    cfg_write(3'd6, 24'd2);        cfg_write(3'd7, 24'd1);
    cap_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fcw0 !== 24'd16777211) begin errors++; $display("FAIL wrap_base got %0d want 16777211", fcw0); end
    repeat (10) tick();
    checks++;
    if (fcw_upd !== 1'b1 || fcw0 !== 24'd5 || fcw1 !== 24'd220) begin
      errors++; $display("FAIL wrap_step got upd=%b fcw0=%0d fcw1=%0d want 1 5 220", fcw_upd, fcw0, fcw1);
    end
    repeat (10) tick();
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL wrap_done got done=%b busy=%b want 1 0", done, busy); end
    tick();
  endtask

  task automatic test_abort();
    int d0;
    cfg_write(3'd0, 24'd100); cfg_write(3'd6, 24'd3); cfg_write(3'd7, 24'd4);
    cap_ready = 1'b1;
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    repeat (13) tick();
    checks++;
    if (fcw_upd !== 1'b1 || fcw0 !== 24'd110) begin
      errors++; $display("FAIL ab_upd1 got upd=%b fcw0=%0d want 1 110", fcw_upd, fcw0);
    end
    repeat (8) tick();
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 24'd999;
    tick();
    cfg_we = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, cap_valid, fcw_upd} !== 3'b000 || fcw0 !== 24'd110 || fcw1 !== 24'd220) begin
      errors++; $display("FAIL ab_stop got busy=%b cv=%b upd=%b fcw0=%0d fcw1=%0d want 0 0 0 110 220",
                         busy, cap_valid, fcw_upd, fcw0, fcw1);
    end
    repeat (10) tick();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0 || fcw0 !== 24'd110) begin
      errors++; $display("FAIL ab_quiet got pulses=%0d busy=%b fcw0=%0d want 0 0 110", done_cnt - d0, busy, fcw0);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fcw_upd !== 1'b1 || fcw1 !== 24'd200) begin
      errors++; $display("FAIL ab_busy_write got upd=%b fcw1=%0d want 1 200", fcw_upd, fcw1);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ab_settle got busy=%b want 0", busy); end
    cfg_write(3'd1, 24'd555);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fcw1 !== 24'd555) begin errors++; $display("FAIL ab_idle_write got fcw1=%0d want 555", fcw1); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_corner();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    checks++;
    if ({fcw_upd, busy} !== 2'b00 || fcw1 !== 24'd555) begin
      errors++; $display("FAIL sa_same got upd=%b busy=%b fcw1=%0d want 0 0 555", fcw_upd, busy, fcw1);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sa_idle got busy=%b want 0", busy); end

    cfg_write(3'd6, 24'd0); cfg_write(3'd7, 24'd0);
    cap_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    checks++;
    if (cap_valid !== 1'b1 || cap_idx !== 16'd0) begin
      errors++; $display("FAIL zero_cap got cv=%b idx=%0d want 1 0", cap_valid, cap_idx);
    end
    tick();
    checks++;
    if ({cap_valid, done} !== 2'b00) begin errors++; $display("FAIL zero_dwell got cv=%b done=%b want 0 0", cap_valid, done); end
    tick();
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done got done=%b busy=%b want 1 0", done, busy); end
    tick();

    cfg_write(3'd6, 24'd2); cfg_write(3'd7, 24'd3); cfg_write(3'd0, 24'd77);
    cap_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fcw0 !== 24'd77) begin errors++; $display("FAIL rst_pre_load got fcw0=%0d want 77", fcw0); end
    repeat (8) tick();
    checks++;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_cap got cv=%b want 1", cap_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({cap_valid, busy} !== 2'b00 || fcw0 !== 24'd0 || fcw1 !== 24'd0) begin
      errors++; $display("FAIL rst_mid got cv=%b busy=%b fcw0=%0d fcw1=%0d want 0 0 0 0", cap_valid, busy, fcw0, fcw1);
    end
    cap_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fcw_upd !== 1'b1 || fcw0 !== 24'd0 || fcw1 !== 24'd0) begin
      errors++; $display("FAIL rst_cfg_base got upd=%b fcw0=%0d fcw1=%0d want 1 0 0", fcw_upd, fcw0, fcw1);
    end
    repeat (8) tick();
    checks++;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL rst_cfg_cap got cv=%b want 1", cap_valid); end
    repeat (2) tick();
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL rst_cfg_defaults got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0; cap_ready = 1'b0;
    test_reset();
    test_defaults();
    test_multi_step();
    test_backpressure();
    test_wrap();
    test_abort();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
